// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the I/D cache memory arbiter: FSM encoding, port IDs,
// default line width and the round-robin pick rule.
package mem_arbiter_pkg;

    localparam int MEMORY_WIDTH = 128;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // On a tie the port that was not served last wins.
    function automatic logic rr_pick(input logic pend_i, input logic pend_d, input logic last);
        if (pend_i && pend_d) begin
            return ~last;
        end
        return pend_d ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; remembers the last granted port so ties alternate.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_o,
    output logic       valid_o
);

    logic last_q;

    assign gnt_o   = rr_pick(req_i[PORT_I], req_i[PORT_D], last_q);
    assign valid_o = |req_i;

    // Reset to D so the I side wins the very first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_D;
        end else if (update_i && valid_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory port between the I and D caches; one transaction
// at a time, write before read within a port, round-robin across ports.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int    WIDTH = MEMORY_WIDTH,
    parameter string ALIAS = "memarb"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_write_req,
    input  logic [31:0]      i_write_addr,
    input  logic [WIDTH-1:0] i_write_data,
    output logic             i_write_ack,
    input  logic             i_read_req,
    input  logic [31:0]      i_read_addr,
    output logic [WIDTH-1:0] i_read_data,
    output logic             i_read_ack,
    input  logic             d_write_req,
    input  logic [31:0]      d_write_addr,
    input  logic [WIDTH-1:0] d_write_data,
    output logic             d_write_ack,
    input  logic             d_read_req,
    input  logic [31:0]      d_read_addr,
    output logic [WIDTH-1:0] d_read_data,
    output logic             d_read_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    logic [1:0]       state_q, state_d;
    logic             port_q, port_d;
    logic             we_q, we_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic [1:0] pend;
    logic       gnt;
    logic       gnt_valid;
    logic       in_idle;
    logic       in_resp;

    assign pend[PORT_I] = i_write_req | i_read_req;
    assign pend[PORT_D] = d_write_req | d_read_req;
    assign in_idle      = (state_q == ST_IDLE);
    assign in_resp      = (state_q == ST_RESP);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (pend),
        .update_i (in_idle),
        .gnt_o    (gnt),
        .valid_o  (gnt_valid)
    );

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt;
                    req_d   = 1'b1;
                    state_d = ST_BUSY;
                    if (gnt == PORT_D) begin
                        we_d    = d_write_req;
                        addr_d  = d_write_req ? d_write_addr : d_read_addr;
                        wdata_d = d_write_data;
                    end else begin
                        we_d    = i_write_req;
                        addr_d  = i_write_req ? i_write_addr : i_read_addr;
                        wdata_d = i_write_data;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (port_q == PORT_D) d_rdata_d = mem_rdata;
                        else                  i_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset mid-transaction just abandons it; a late mem_ack lands in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_I;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_read_data = i_rdata_q;
    assign d_read_data = d_rdata_q;

    // RESP lasts exactly one cycle, so these are single-cycle pulses.
    assign i_write_ack = in_resp && (port_q == PORT_I) &&  we_q;
    assign i_read_ack  = in_resp && (port_q == PORT_I) && !we_q;
    assign d_write_ack = in_resp && (port_q == PORT_D) &&  we_q;
    assign d_read_ack  = in_resp && (port_q == PORT_D) && !we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int W = 64;

    localparam logic [31:0]  I_WA = 32'h0000_0080;
    localparam logic [31:0]  I_RA = 32'h0000_0040;
    localparam logic [31:0]  D_WA = 32'h0000_0100;
    localparam logic [31:0]  D_RA = 32'h0000_0200;
    localparam logic [W-1:0] I_WD = 64'h1111_2222_3333_4444;
    localparam logic [W-1:0] D_WD = 64'h1234_5678_9abc_def0;
    localparam logic [W-1:0] PAT  = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         i_write_req, i_write_ack, i_read_req, i_read_ack;
    logic [31:0]  i_write_addr, i_read_addr;
    logic [W-1:0] i_write_data, i_read_data;
    logic         d_write_req, d_write_ack, d_read_req, d_read_ack;
    logic [31:0]  d_write_addr, d_read_addr;
    logic [W-1:0] d_write_data, d_read_data;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [W-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.WIDTH(W), .ALIAS("memarb")) dut (
        .clk(clk), .reset(reset),
        .i_write_req(i_write_req), .i_write_addr(i_write_addr), .i_write_data(i_write_data),
        .i_write_ack(i_write_ack), .i_read_req(i_read_req), .i_read_addr(i_read_addr),
        .i_read_data(i_read_data), .i_read_ack(i_read_ack),
        .d_write_req(d_write_req), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
        .d_write_ack(d_write_ack), .d_read_req(d_read_req), .d_read_addr(d_read_addr),
        .d_read_data(d_read_data), .d_read_ack(d_read_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected acks packed as {i_write, i_read, d_write, d_read}.
    task automatic chk_outs(input string tag, input logic ereq, input logic ewe,
                            input logic [31:0] ea, input logic [W-1:0] ewd,
                            input logic [3:0] eack, input logic [W-1:0] erd);
        chk({tag, ".mem_req"}, 128'(mem_req), 128'(ereq));
        if (ereq) begin
            chk({tag, ".mem_we"}, 128'(mem_we), 128'(ewe));
            chk({tag, ".mem_addr"}, 128'(mem_addr), 128'(ea));
            if (ewe) chk({tag, ".mem_wdata"}, 128'(mem_wdata), 128'(ewd));
        end
        chk({tag, ".acks"}, 128'({i_write_ack, i_read_ack, d_write_ack, d_read_ack}), 128'(eack));
        if (eack[2]) chk({tag, ".i_read_data"}, 128'(i_read_data), 128'(erd));
        if (eack[0]) chk({tag, ".d_read_data"}, 128'(d_read_data), 128'(erd));
    endtask

    typedef struct {
        logic        rst, iw, ir, dw, dr, ack;
        logic        ereq, ewe;
        logic [31:0] eaddr;
        logic [3:0]  eack;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic iw, input logic ir, input logic dw,
                                input logic dr, input logic ack, input logic ereq, input logic ewe,
                                input logic [31:0] ea, input logic [3:0] eack);
        vec_t v;
        v.rst = rst; v.iw = iw; v.ir = ir; v.dw = dw; v.dr = dr; v.ack = ack;
        v.ereq = ereq; v.ewe = ewe; v.eaddr = ea; v.eack = eack;
        return v;
    endfunction

    // Random-phase stimulus state, index 0 = I, 1 = D.
    logic         pw[2], pr[2];
    logic [31:0]  wa[2], ra[2];
    logic [W-1:0] wd[2];

    task automatic drive_ports();
        i_write_req = pw[0]; i_write_addr = wa[0]; i_write_data = wd[0];
        i_read_req  = pr[0]; i_read_addr  = ra[0];
        d_write_req = pw[1]; d_write_addr = wa[1]; d_write_data = wd[1];
        d_read_req  = pr[1]; d_read_addr  = ra[1];
    endtask

    initial begin
        vec_t tv[$];
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = PAT;
        i_write_req = 1'b0; i_read_req = 1'b0; d_write_req = 1'b0; d_read_req = 1'b0;
        i_write_addr = I_WA; i_read_addr = I_RA; i_write_data = I_WD;
        d_write_addr = D_WA; d_read_addr = D_RA; d_write_data = D_WD;

        //            rst iw ir dw dr ack  req we addr   acks
        tv.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0,    4'b0000)); // reset state
        tv.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0,    4'b0000)); // spurious ack in IDLE
        tv.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, I_RA, 4'b0000)); // single I read
        tv.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, I_RA, 4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, I_RA, 4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 0, 1,   0, 0, 0,    4'b0100));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 0, 1, 1, 0,   1, 1, D_WA, 4'b0000)); // D evict then fill
        tv.push_back(mk(0, 0, 0, 1, 1, 1,   0, 0, 0,    4'b0010));
        tv.push_back(mk(0, 0, 0, 0, 1, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 0, 0, 1, 0,   1, 0, D_RA, 4'b0000));
        tv.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0, 0,    4'b0001));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 1, 0,   1, 0, I_RA, 4'b0000)); // tie: I first
        tv.push_back(mk(0, 0, 1, 0, 1, 1,   0, 0, 0,    4'b0100));
        tv.push_back(mk(0, 0, 0, 0, 1, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 0, 0, 1, 0,   1, 0, D_RA, 4'b0000));
        tv.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0, 0,    4'b0001));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 1, 0,   1, 0, I_RA, 4'b0000)); // both held: alternate
        tv.push_back(mk(0, 0, 1, 0, 1, 1,   0, 0, 0,    4'b0100));
        tv.push_back(mk(0, 0, 1, 0, 1, 1,   0, 0, 0,    4'b0000)); // ack in RESP ignored
        tv.push_back(mk(0, 0, 1, 0, 1, 0,   1, 0, D_RA, 4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 1, 1,   0, 0, 0,    4'b0001));
        tv.push_back(mk(0, 0, 1, 0, 1, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 1, 0,   1, 0, I_RA, 4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 1, 1,   0, 0, 0,    4'b0100));
        tv.push_back(mk(0, 1, 0, 0, 0, 1,   0, 0, 0,    4'b0000)); // RESP: no grant yet
        tv.push_back(mk(0, 1, 1, 0, 0, 0,   1, 1, I_WA, 4'b0000)); // write before read
        tv.push_back(mk(0, 1, 1, 0, 0, 1,   0, 0, 0,    4'b1000));
        tv.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0,    4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, I_RA, 4'b0000));
        tv.push_back(mk(0, 0, 1, 0, 0, 1,   0, 0, 0,    4'b0100));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,    4'b0000));

        for (int k = 0; k < tv.size(); k++) begin
            reset = tv[k].rst; i_write_req = tv[k].iw; i_read_req = tv[k].ir;
            d_write_req = tv[k].dw; d_read_req = tv[k].dr; mem_ack = tv[k].ack;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", k), tv[k].ereq, tv[k].ewe, tv[k].eaddr,
                     tv[k].eaddr == I_WA ? I_WD : D_WD, tv[k].eack, PAT);
        end
        mem_ack = 1'b0; i_write_req = 1'b0; i_read_req = 1'b0; d_write_req = 1'b0; d_read_req = 1'b0;

        // Back-pressure: memory stalls 20 cycles, request fields must hold.
        i_write_req = 1'b1;
        @(negedge clk); chk_outs("bp.grant", 1, 1, I_WA, I_WD, 4'b0000, PAT);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); chk_outs("bp.hold", 1, 1, I_WA, I_WD, 4'b0000, PAT);
        end
        mem_ack = 1'b1;
        @(negedge clk); chk_outs("bp.ack", 0, 0, 0, 0, 4'b1000, PAT);
        mem_ack = 1'b0; i_write_req = 1'b0;
        @(negedge clk); chk_outs("bp.idle", 0, 0, 0, 0, 4'b0000, PAT);

        // Reset while BUSY (I granted, so last grant is I before reset).
        i_read_req = 1'b1;
        @(negedge clk); chk_outs("rst.grant", 1, 0, I_RA, 0, 4'b0000, PAT);
        i_read_req = 1'b0; reset = 1'b1;
        @(negedge clk); chk_outs("rst.cut", 0, 0, 0, 0, 4'b0000, PAT);
        reset = 1'b0;
        @(negedge clk); chk_outs("rst.wait", 0, 0, 0, 0, 4'b0000, PAT);
        mem_ack = 1'b1;
        @(negedge clk); chk_outs("rst.lateack", 0, 0, 0, 0, 4'b0000, PAT);
        mem_ack = 1'b0; i_read_req = 1'b1; d_read_req = 1'b1;
        @(negedge clk); chk_outs("rst.lastD", 1, 0, I_RA, 0, 4'b0000, PAT);
        mem_ack = 1'b1;
        @(negedge clk); chk_outs("rst.done", 0, 0, 0, 0, 4'b0100, PAT);
        mem_ack = 1'b0; i_read_req = 1'b0; d_read_req = 1'b0;

        // Randomized traffic against a transaction-level model.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pw[p] = 1'b0; pr[p] = 1'b0; wa[p] = '0; ra[p] = '0; wd[p] = '0;
        end
        drive_ports();
        begin
            int           phase;  // 0 free, 1 transaction outstanding, 2 ack cycle
            int           dly;
            logic         lastg, g, gwe, pi, pd;
            logic [31:0]  gaddr;
            logic [W-1:0] gwd, rdv;
            logic [3:0]   eack;
            phase = 0; dly = 0; lastg = 1'b1; g = 1'b0; gwe = 1'b0;
            gaddr = '0; gwd = '0; rdv = '0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                pi = pw[0] | pr[0];
                pd = pw[1] | pr[1];
                if (phase == 0) begin
                    if (pi || pd) begin
                        g     = (pi && pd) ? ~lastg : pd;
                        lastg = g;
                        gwe   = pw[g];
                        gaddr = gwe ? wa[g] : ra[g];
                        gwd   = wd[g];
                        phase = 1;
                        dly   = $urandom_range(0, 6);
                        chk_outs("rnd.grant", 1, gwe, gaddr, gwd, 4'b0000, 0);
                    end else begin
                        chk_outs("rnd.idle", 0, 0, 0, 0, 4'b0000, 0);
                    end
                end else if (phase == 1) begin
                    if (mem_ack) begin
                        eack = (g == 1'b0) ? (gwe ? 4'b1000 : 4'b0100)
                                           : (gwe ? 4'b0010 : 4'b0001);
                        chk_outs("rnd.ack", 0, 0, 0, 0, eack, rdv);
                        if (gwe) pw[g] = 1'b0;
                        else     pr[g] = 1'b0;
                        phase = 2;
                    end else begin
                        chk_outs("rnd.busy", 1, gwe, gaddr, gwd, 4'b0000, 0);
                    end
                end else begin
                    chk_outs("rnd.resp", 0, 0, 0, 0, 4'b0000, 0);
                    phase = 0;
                end

                if (phase == 1) begin
                    if (dly == 0) begin
                        mem_ack = 1'b1;
                        rdv = {$urandom, $urandom};
                        mem_rdata = rdv;
                    end else begin
                        dly--;
                        mem_ack = 1'b0;
                    end
                end else begin
                    mem_ack = ($urandom_range(0, 7) == 0);
                    mem_rdata = {$urandom, $urandom};
                end
                for (int p = 0; p < 2; p++) begin
                    if (!pw[p] && !pr[p] && $urandom_range(0, 3) == 0) begin
                        int kind;
                        kind  = $urandom_range(1, 3);
                        pw[p] = kind[0];
                        pr[p] = kind[1];
                        wa[p] = $urandom & 32'hFFFF_FFC0;
                        ra[p] = $urandom & 32'hFFFF_FFC0;
                        wd[p] = {$urandom, $urandom};
                    end
                end
                drive_ports();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
